// File: rtl/cordic_vectoring_if.sv
// Start/busy/done handshake plus operand and result buses for the vectoring CORDIC.
// The master drives the request; the slave (the CORDIC) returns polar results.
interface cordic_vectoring_if;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] magnitude;
    logic [31:0] angle;
    logic        range_err;

    modport master (
        output start, x, y,
        input  busy, done, magnitude, angle, range_err
    );

    modport slave (
        input  start, x, y,
        output busy, done, magnitude, angle, range_err
    );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative circular-vectoring CORDIC: IEEE-754 (x,y) in, magnitude and atan2 in degrees out.
// One micro-rotation per cycle; result latency is ITER+3 cycles from the accepting edge.
module cordic_vectoring #(
    parameter int ITER = 24,
    parameter int DW   = 40,
    parameter int FRAC = 28
) (
    input logic               clk,
    input logic               rst,
    cordic_vectoring_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_SCALE = 3'd3;
    localparam logic [2:0] S_PACK  = 3'd4;

    localparam int  CW          = (ITER > 1) ? $clog2(ITER) : 1;
    localparam real SCALE       = 2.0 ** FRAC;
    localparam int  UNPACK_BIAS = 150 - FRAC;
    localparam int  RANGE_EXP   = 135;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] F180 = 32'h4334_0000;
    localparam logic signed [DW-1:0] INV_K   = DW'(longint'(0.607252935 * SCALE));
    localparam logic signed [DW-1:0] DEG90   = DW'(longint'(90.0 * SCALE));
    localparam logic signed [DW-1:0] DEG180  = DW'(longint'(180.0 * SCALE));
    localparam logic signed [DW-1:0] RAD2DEG = DW'(longint'(57.29577951308232 * SCALE));

    function automatic logic signed [DW-1:0] atanDeg(input logic [CW-1:0] idx);
        logic signed [DW-1:0] r;
        case (int'(idx))
            0:  r = DW'(longint'(45.0 * SCALE));
            1:  r = DW'(longint'(26.565051177077989 * SCALE));
            2:  r = DW'(longint'(14.036243467926479 * SCALE));
            3:  r = DW'(longint'(7.125016348901798 * SCALE));
            4:  r = DW'(longint'(3.576334374997351 * SCALE));
            5:  r = DW'(longint'(1.789910608246069 * SCALE));
            6:  r = DW'(longint'(0.895173710211074 * SCALE));
            7:  r = DW'(longint'(0.447614170860553 * SCALE));
            8:  r = DW'(longint'(0.223810500368538 * SCALE));
            9:  r = DW'(longint'(0.111905677066207 * SCALE));
            10: r = DW'(longint'(0.055952891893804 * SCALE));
            11: r = DW'(longint'(0.027976452617004 * SCALE));
            12: r = DW'(longint'(0.013988227142265 * SCALE));
            13: r = DW'(longint'(0.006994113675353 * SCALE));
            14: r = DW'(longint'(0.003497056850704 * SCALE));
            15: r = DW'(longint'(0.001748528426980 * SCALE));
            16: r = DW'(longint'(0.000874264213694 * SCALE));
            17: r = DW'(longint'(0.000437132106872 * SCALE));
            18: r = DW'(longint'(0.000218566053439 * SCALE));
            19: r = DW'(longint'(0.000109283026720 * SCALE));
            20: r = DW'(longint'(0.000054641513360 * SCALE));
            21: r = DW'(longint'(0.000027320756680 * SCALE));
            22: r = DW'(longint'(0.000013660378340 * SCALE));
            23: r = DW'(longint'(0.000006830189170 * SCALE));
            default: r = RAD2DEG >>> idx;
        endcase
        return r;
    endfunction

    // Out-of-range exponents return 0; range_err masks the result anyway.
    function automatic logic signed [DW-1:0] toFixed(input logic [31:0] f);
        int          ee;
        logic [63:0] mant;
        logic [63:0] mag;
        ee   = int'(f[30:23]);
        mant = {40'd0, 1'b1, f[22:0]};
        mag  = '0;
        if (ee != 0 && ee < RANGE_EXP) begin
            if (ee >= UNPACK_BIAS) mag = mant << (ee - UNPACK_BIAS);
            else                   mag = mant >> (UNPACK_BIAS - ee);
        end
        return f[31] ? -DW'(mag) : DW'(mag);
    endfunction

    function automatic logic [31:0] toFloat(input logic signed [DW-1:0] v);
        logic [DW-1:0] m;
        logic [DW-1:0] norm;
        int            p;
        m    = v[DW-1] ? -v : v;
        p    = 0;
        norm = '0;
        for (int i = 0; i < DW; i++) begin
            if (m[i]) p = i;
        end
        if (m == '0) return 32'h0;
        if (p >= 23) norm = m >> (p - 23);
        else         norm = m << (23 - p);
        return {v[DW-1], 8'(p - FRAC + 127), 23'(norm)};
    endfunction

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        iter_q, iter_d;
    logic [31:0]          xIn_q, xIn_d, yIn_q, yIn_d;
    logic signed [DW-1:0] xAcc_q, xAcc_d, yAcc_q, yAcc_d, zAcc_q, zAcc_d;
    logic                 rangePend_q, rangePend_d, zeroIn_q, zeroIn_d, negAxis_q, negAxis_d;
    logic                 busy_q, busy_d, done_q, done_d, rangeErr_q, rangeErr_d;
    logic [31:0]          mag_q, mag_d, ang_q, ang_d;
    logic signed [DW-1:0] xFix, yFix, xSh, ySh, atanStep;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        xIn_d       = xIn_q;
        yIn_d       = yIn_q;
        xAcc_d      = xAcc_q;
        yAcc_d      = yAcc_q;
        zAcc_d      = zAcc_q;
        rangePend_d = rangePend_q;
        zeroIn_d    = zeroIn_q;
        negAxis_d   = negAxis_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rangeErr_d  = rangeErr_q;
        mag_d       = mag_q;
        ang_d       = ang_q;
        xFix        = toFixed(xIn_q);
        yFix        = toFixed(yIn_q);
        xSh         = xAcc_q >>> iter_q;
        ySh         = yAcc_q >>> iter_q;
        atanStep    = atanDeg(iter_q);
        prod        = (2*DW)'(xAcc_q) * (2*DW)'(INV_K);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    xIn_d   = bus.x;
                    yIn_d   = bus.y;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rangePend_d = (int'(xIn_q[30:23]) >= RANGE_EXP) || (int'(yIn_q[30:23]) >= RANGE_EXP);
                zeroIn_d    = (xFix == '0) && (yFix == '0);
                negAxis_d   = xFix[DW-1] && (yFix == '0);
                iter_d      = '0;
                state_d     = S_ITER;
                // Fold the left half-plane into the right so iterations converge.
                if (!xFix[DW-1]) begin
                    xAcc_d = xFix;  yAcc_d = yFix;  zAcc_d = '0;
                end else if (!yFix[DW-1]) begin
                    xAcc_d = yFix;  yAcc_d = -xFix; zAcc_d = DEG90;
                end else begin
                    xAcc_d = -yFix; yAcc_d = xFix;  zAcc_d = -DEG90;
                end
            end
            S_ITER: begin
                if (!yAcc_q[DW-1]) begin
                    xAcc_d = xAcc_q + ySh;
                    yAcc_d = yAcc_q - xSh;
                    zAcc_d = zAcc_q + atanStep;
                end else begin
                    xAcc_d = xAcc_q - ySh;
                    yAcc_d = yAcc_q + xSh;
                    zAcc_d = zAcc_q - atanStep;
                end
                if (iter_q == CW'(ITER - 1)) state_d = S_SCALE;
                else                         iter_d  = iter_q + 1'b1;
            end
            S_SCALE: begin
                xAcc_d  = DW'(prod >>> FRAC);
                state_d = S_PACK;
            end
            S_PACK: begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_IDLE;
                rangeErr_d = rangePend_q;
                if (rangePend_q) begin
                    mag_d = QNAN;
                    ang_d = QNAN;
                end else begin
                    mag_d = toFloat(xAcc_q);
                    // Keep the result in (-180,180] even when the last micro-rotation overshoots.
                    if (zeroIn_q)
                        ang_d = 32'h0;
                    else if (negAxis_q || zAcc_q > DEG180 || zAcc_q <= -DEG180)
                        ang_d = F180;
                    else
                        ang_d = toFloat(zAcc_q);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            iter_q      <= '0;
            xIn_q       <= '0;
            yIn_q       <= '0;
            xAcc_q      <= '0;
            yAcc_q      <= '0;
            zAcc_q      <= '0;
            rangePend_q <= 1'b0;
            zeroIn_q    <= 1'b0;
            negAxis_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rangeErr_q  <= 1'b0;
            mag_q       <= '0;
            ang_q       <= '0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            xIn_q       <= xIn_d;
            yIn_q       <= yIn_d;
            xAcc_q      <= xAcc_d;
            yAcc_q      <= yAcc_d;
            zAcc_q      <= zAcc_d;
            rangePend_q <= rangePend_d;
            zeroIn_q    <= zeroIn_d;
            negAxis_q   <= negAxis_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rangeErr_q  <= rangeErr_d;
            mag_q       <= mag_d;
            ang_q       <= ang_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.magnitude = mag_q;
    assign bus.angle     = ang_q;
    assign bus.range_err = rangeErr_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed-vector bench for cordic_vectoring; float results are compared within a tolerance in ULPs.
module tb_cordic_vectoring;
    localparam int LATENCY = 27;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] SQRT2 = 32'h3FB5_04F3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   failCount  = 0;

    cordic_vectoring_if bus ();

    cordic_vectoring dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic longint ordOf(input logic [31:0] b);
        return b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    endfunction

    // Distance between float bit patterns in ULPs; tol 0 means exact match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected, input int tolUlp);
        longint diff;
        checkCount++;
        diff = ordOf(observed) - ordOf(expected);
        if (diff < 0) diff = -diff;
        if (diff > longint'(tolUlp)) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (+/- %0d ulp)", tag, observed, expected, tolUlp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] yv, output int latency);
        @(negedge clk);
        bus.x     = xv;
        bus.y     = yv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busyAtAccept", 32'(bus.busy), 32'd1, 0);
        latency = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic runVector(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                             input logic [31:0] expMag, input int magTol,
                             input logic [31:0] expAng, input int angTol, input logic expErr);
        int lat;
        applyStimulus(xv, yv, lat);
        checkOutput({tag, ".lat"}, 32'(lat), 32'(LATENCY), 0);
        checkOutput({tag, ".mag"}, bus.magnitude, expMag, magTol);
        if (angTol >= 0) checkOutput({tag, ".ang"}, bus.angle, expAng, angTol);
        checkOutput({tag, ".err"}, 32'(bus.range_err), 32'(expErr), 0);
    endtask

    initial begin
        int first;
        int second;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.busy", 32'(bus.busy), 32'd0, 0);
        checkOutput("rst.done", 32'(bus.done), 32'd0, 0);
        checkOutput("rst.mag", bus.magnitude, 32'h0, 0);
        checkOutput("rst.ang", bus.angle, 32'h0, 0);
        checkOutput("rst.err", 32'(bus.range_err), 32'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        runVector("diag45", ONE, ONE, SQRT2, 8, 32'h4234_0000, 26, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("diag45.donePulse", 32'(bus.done), 32'd0, 0);
        runVector("deg30", 32'h3F5D_B3D7, 32'h3F00_0000, ONE, 8, 32'h41F0_0000, 50, 1'b0);
        runVector("negAxis", 32'hBF80_0000, 32'h0, ONE, 8, 32'h4334_0000, 0, 1'b0);
        runVector("negY", 32'h0, 32'hC000_0000, 32'h4000_0000, 8, 32'hC2B4_0000, 12, 1'b0);
        runVector("zero", 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0);
        runVector("denorm", 32'h0000_0001, 32'h8000_0001, 32'h0, 0, 32'h0, 0, 1'b0);
        runVector("q2", 32'hBF80_0000, ONE, SQRT2, 8, 32'h4307_0000, 6, 1'b0);
        runVector("t345", 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 8, 32'h4254_8539, 26, 1'b0);
        runVector("x255", 32'h437F_0000, 32'h0, 32'h437F_0000, 8, 32'h0, -1, 1'b0);
        runVector("x256", 32'h4380_0000, 32'h0, QNAN, 0, QNAN, 0, 1'b1);
        runVector("yInf", 32'h0, 32'h7F80_0000, QNAN, 0, QNAN, 0, 1'b1);

        // start held high: the second request is taken only after done, with x,y at that edge
        @(negedge clk);
        bus.x     = ONE;
        bus.y     = ONE;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.x  = 32'h4040_0000;
        bus.y  = 32'h4080_0000;
        first  = -1;
        second = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (first < 0) begin
                    first = k;
                    checkOutput("held.mag1", bus.magnitude, SQRT2, 8);
                end else begin
                    second = k;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checkOutput("held.first", 32'(first), 32'(LATENCY), 0);
        checkOutput("held.gap", 32'(second - first), 32'(LATENCY + 1), 0);
        checkOutput("held.mag2", bus.magnitude, 32'h40A0_0000, 8);

        // asynchronous reset between edges while iterating
        @(negedge clk);
        bus.x     = ONE;
        bus.y     = ONE;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midRst.mag", bus.magnitude, 32'h0, 0);
        checkOutput("midRst.ang", bus.angle, 32'h0, 0);
        checkOutput("midRst.busy", 32'(bus.busy), 32'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        runVector("postRst", 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 8, 32'h4254_8539, 26, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
